// File: rtl/bp_ctrl.sv
// bp_ctrl: branch-prediction controller. Holds a PC-indexed table of 2-bit
// saturating counters, queues in-flight IF predictions in program order and
// checks each EX resolution against the oldest one. On a mispredict it issues
// a registered redirect and drops the wrong-path queue contents. After reset
// it sweeps the table to "weakly not taken" before accepting work.
module bp_ctrl #(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid_i,
    input  logic [31:0] pred_addr_i,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_target_i,
    output logic        bht_taken_o,
    output logic        ready_o,
    input  logic        res_valid_i,
    input  logic        res_taken_i,
    input  logic [31:0] res_target_i,
    input  logic        flush_i,
    output logic        redirect_o,
    output logic [31:0] redirect_addr_o,
    output logic [1:0]  branch_taken_o,
    output logic [15:0] mispredict_cnt_o,
    output logic        busy_init_o,
    output logic        err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TBL_N = 1 << IDX_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_idx_q, init_idx_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               redirect_q, redirect_d;
    logic [31:0]        redirect_addr_q, redirect_addr_d;
    logic [1:0]         branch_taken_q, branch_taken_d;
    logic [15:0]        mis_cnt_q, mis_cnt_d;
    logic               err_q, err_d;

    // Counter table and prediction queue storage.
    logic [1:0]         bht_q [TBL_N];
    logic [31:0]        q_addr_q [DEPTH];
    logic               q_taken_q [DEPTH];
    logic [31:0]        q_target_q [DEPTH];

    // Per-cycle control decided in the next-state logic.
    logic               bht_we;
    logic [IDX_W-1:0]   bht_widx;
    logic [1:0]         bht_wdata;
    logic               q_push;
    logic               do_pop;
    logic               do_clear;

    // Head entry of the queue and its comparison against the EX outcome.
    logic [31:0]        h_addr;
    logic               h_taken;
    logic [31:0]        h_target;
    logic [IDX_W-1:0]   h_idx;
    logic [1:0]         h_ctr;
    logic               mispredict;

    assign h_addr     = q_addr_q[head_q];
    assign h_taken    = q_taken_q[head_q];
    assign h_target   = q_target_q[head_q];
    assign h_idx      = h_addr[IDX_W+1:2];
    assign h_ctr      = bht_q[h_idx];
    assign mispredict = (res_taken_i != h_taken) || (res_taken_i && (h_target != res_target_i));

    // The lookup reads the stored counter, so a same-cycle update is not bypassed.
    assign bht_taken_o      = (state_q == ST_RUN) && bht_q[pred_addr_i[IDX_W+1:2]][1];
    assign ready_o          = (state_q == ST_RUN) && (count_q < DEPTH_C);
    assign busy_init_o      = (state_q == ST_INIT);
    assign redirect_o       = redirect_q;
    assign redirect_addr_o  = redirect_addr_q;
    assign branch_taken_o   = branch_taken_q;
    assign mispredict_cnt_o = mis_cnt_q;
    assign err_o            = err_q;

    // Next-state: init sweep, push/pop/clear decisions, training and redirect.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d         = state_q;
        init_idx_d      = init_idx_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        redirect_d      = 1'b0;
        redirect_addr_d = redirect_addr_q;
        branch_taken_d  = 2'b00;
        mis_cnt_d       = mis_cnt_q;
        err_d           = err_q;
        bht_we          = 1'b0;
        bht_widx        = '0;
        bht_wdata       = 2'b01;
        q_push          = 1'b0;
        do_pop          = 1'b0;
        do_clear        = 1'b0;

        case (state_q)
            ST_INIT: begin
                bht_we     = 1'b1;
                bht_widx   = init_idx_q;
                bht_wdata  = 2'b01;
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                q_push = pred_valid_i && ready_o;
                if (flush_i) begin
                    // Flush discards everything in flight; the trap logic owns the refetch PC.
                    q_push   = 1'b0;
                    do_clear = 1'b1;
                end else if (res_valid_i && (count_q == '0)) begin
                    err_d = 1'b1;
                end else if (res_valid_i) begin
                    bht_we   = 1'b1;
                    bht_widx = h_idx;
                    if (res_taken_i) begin
                        bht_wdata      = (h_ctr == 2'b11) ? 2'b11 : h_ctr + 2'd1;
                        branch_taken_d = 2'b10;
                    end else begin
                        bht_wdata      = (h_ctr == 2'b00) ? 2'b00 : h_ctr - 2'd1;
                        branch_taken_d = 2'b01;
                    end
                    if (mispredict) begin
                        // Everything younger than the head, including this cycle's push, is wrong-path.
                        q_push          = 1'b0;
                        do_clear        = 1'b1;
                        redirect_d      = 1'b1;
                        redirect_addr_d = res_taken_i ? res_target_i : h_addr + 32'd4;
                        mis_cnt_d       = (mis_cnt_q == 16'hFFFF) ? mis_cnt_q : mis_cnt_q + 16'd1;
                    end else begin
                        do_pop = 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (do_clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (q_push) tail_d = tail_q + 1'b1;
            if (do_pop) head_d = head_q + 1'b1;
            count_d = count_q + CNT_W'(q_push) - CNT_W'(do_pop);
        end
    end

    // Control and output registers; reset restarts the init sweep from any state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q         <= ST_INIT;
            init_idx_q      <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            redirect_q      <= 1'b0;
            redirect_addr_q <= '0;
            branch_taken_q  <= 2'b00;
            mis_cnt_q       <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            init_idx_q      <= init_idx_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            redirect_q      <= redirect_d;
            redirect_addr_q <= redirect_addr_d;
            branch_taken_q  <= branch_taken_d;
            mis_cnt_q       <= mis_cnt_d;
            err_q           <= err_d;
        end
    end

    // Counter table write port: init sweep or resolution training.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; the init sweep and the count/pointers make contents valid.
        if (bht_we) begin
            bht_q[bht_widx] <= bht_wdata;
        end
    end

    // Queue entry write at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (q_push) begin
            q_addr_q[tail_q]   <= pred_addr_i;
            q_taken_q[tail_q]  <= pred_taken_i;
            q_target_q[tail_q] <= pred_target_i;
        end
    end

endmodule

// File: tb/tb_bp_ctrl.sv
// tb_bp_ctrl: directed scenarios followed by randomized traffic, every cycle
// compared against a queue-based behavioural model of the predictor.
module tb_bp_ctrl;

    localparam int IDX_W = 4;
    localparam int DEPTH = 4;
    localparam int TBL_N = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid_i;
    logic [31:0] pred_addr_i;
    logic        pred_taken_i;
    logic [31:0] pred_target_i;
    logic        bht_taken_o;
    logic        ready_o;
    logic        res_valid_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        flush_i;
    logic        redirect_o;
    logic [31:0] redirect_addr_o;
    logic [1:0]  branch_taken_o;
    logic [15:0] mispredict_cnt_o;
    logic        busy_init_o;
    logic        err_o;

    always #5 clk = ~clk;

    bp_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_valid_i     (pred_valid_i),
        .pred_addr_i      (pred_addr_i),
        .pred_taken_i     (pred_taken_i),
        .pred_target_i    (pred_target_i),
        .bht_taken_o      (bht_taken_o),
        .ready_o          (ready_o),
        .res_valid_i      (res_valid_i),
        .res_taken_i      (res_taken_i),
        .res_target_i     (res_target_i),
        .flush_i          (flush_i),
        .redirect_o       (redirect_o),
        .redirect_addr_o  (redirect_addr_o),
        .branch_taken_o   (branch_taken_o),
        .mispredict_cnt_o (mispredict_cnt_o),
        .busy_init_o      (busy_init_o),
        .err_o            (err_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    // Reference model state.
    entry_t      m_q[$];
    int          m_tbl[TBL_N];
    bit          m_known = 1'b0;
    bit          m_run;
    int          m_init_idx;
    bit          m_rst_seen;
    logic        m_redirect;
    logic [31:0] m_redirect_addr;
    logic [1:0]  m_bt;
    int          m_mis;
    bit          m_err;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int tidx(input logic [31:0] a);
        return int'(a[IDX_W+1:2]);
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        entry_t h;
        bit     push_ok;
        bit     mis;
        int     i;
        m_redirect = 1'b0;
        m_bt       = 2'b00;
        m_rst_seen = 1'b0;
        if (rst) begin
            m_known         = 1'b1;
            m_rst_seen      = 1'b1;
            m_run           = 1'b0;
            m_init_idx      = 0;
            m_q.delete();
            m_redirect_addr = 32'h0;
            m_mis           = 0;
            m_err           = 1'b0;
            return;
        end
        if (!m_run) begin
            m_tbl[m_init_idx] = 1;
            m_init_idx++;
            if (m_init_idx == TBL_N) m_run = 1'b1;
            return;
        end
        push_ok = pred_valid_i && (m_q.size() < DEPTH);
        if (flush_i) begin
            m_q.delete();
            return;
        end
        if (res_valid_i && m_q.size() == 0) begin
            m_err = 1'b1;
        end else if (res_valid_i) begin
            h = m_q.pop_front();
            i = tidx(h.addr);
            if (res_taken_i) m_tbl[i] = (m_tbl[i] < 3) ? m_tbl[i] + 1 : 3;
            else             m_tbl[i] = (m_tbl[i] > 0) ? m_tbl[i] - 1 : 0;
            m_bt = res_taken_i ? 2'b10 : 2'b01;
            mis  = (res_taken_i != h.taken) || (res_taken_i && h.target != res_target_i);
            if (mis) begin
                m_redirect      = 1'b1;
                m_redirect_addr = res_taken_i ? res_target_i : h.addr + 32'd4;
                m_q.delete();
                if (m_mis < 65535) m_mis++;
                return;
            end
        end
        if (push_ok) m_q.push_back('{pred_addr_i, pred_taken_i, pred_target_i});
    endtask

    // One clock: check combinational outputs, take the edge, check registered outputs.
    task automatic cycle();
        #1;
        if (m_known) begin
            check("busy_init", 32'(busy_init_o), 32'(!m_run));
            check("ready", 32'(ready_o), 32'(m_run && m_q.size() < DEPTH));
            check("bht_taken", 32'(bht_taken_o), 32'(m_run && m_tbl[tidx(pred_addr_i)] >= 2));
        end
        model_step();
        @(posedge clk);
        #1;
        check("redirect", 32'(redirect_o), 32'(m_redirect));
        if (m_redirect || m_rst_seen) check("redirect_addr", redirect_addr_o, m_redirect_addr);
        check("branch_taken", 32'(branch_taken_o), 32'(m_bt));
        check("mispredict_cnt", 32'(mispredict_cnt_o), 32'(m_mis));
        check("err", 32'(err_o), 32'(m_err));
    endtask

    task automatic set_in(input logic pv, input logic [31:0] pa, input logic pt, input logic [31:0] ptg,
                          input logic rv, input logic rt, input logic [31:0] rtg, input logic fl);
        pred_valid_i  = pv;
        pred_addr_i   = pa;
        pred_taken_i  = pt;
        pred_target_i = ptg;
        res_valid_i   = rv;
        res_taken_i   = rt;
        res_target_i  = rtg;
        flush_i       = fl;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            set_in(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
            cycle();
        end
    endtask

    task automatic pred(input logic [31:0] a, input logic t, input logic [31:0] tg);
        set_in(1, a, t, tg, 0, 0, 32'h0, 0);
        cycle();
    endtask

    task automatic resolve(input logic t, input logic [31:0] tg);
        set_in(0, 32'h0, 0, 32'h0, 1, t, tg, 0);
        cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            set_in(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
            cycle();
        end
        rst = 1'b0;
    endtask

    // Count init cycles after rst drops: busy for 16 cycles, ready on the 17th.
    task automatic check_init_len(input string tag);
        int busy_cycles;
        busy_cycles = 0;
        for (int k = 0; k < 16; k++) begin
            set_in(0, 32'h100 + 32'(k * 4), 0, 32'h0, 1, 1, 32'h0, 1);
            #1;
            if (busy_init_o === 1'b1) busy_cycles++;
            cycle();
        end
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd16);
        #1;
        check({tag, "_ready_after"}, 32'(ready_o), 32'd1);
        check({tag, "_busy_after"}, 32'(busy_init_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);

        // Reset, then a full init sweep with inputs that must be ignored.
        do_reset(2);
        check_init_len("init");

        // Correct not-taken prediction: counter idx 0 drops 01 -> 00.
        pred(32'h100, 0, 32'h0);
        resolve(0, 32'h0);
        check("nt_train_pulse", 32'(branch_taken_o), 32'h1);
        idle(1);
        check("nt_pulse_gone", 32'(branch_taken_o), 32'h0);
        pred_addr_i = 32'h100;
        #1;
        check("nt_lookup_0x100", 32'(bht_taken_o), 32'h0);

        // Mispredict on 0x104: redirect to 0x200, then taken training.
        pred(32'h104, 0, 32'h0);
        resolve(1, 32'h200);
        check("mp_redirect", 32'(redirect_o), 32'h1);
        check("mp_redirect_addr", redirect_addr_o, 32'h200);
        check("mp_count", 32'(mispredict_cnt_o), 32'h1);
        pred(32'h104, 1, 32'h200);
        resolve(1, 32'h200);
        check("ok_no_redirect", 32'(redirect_o), 32'h0);
        pred_addr_i = 32'h104;
        #1;
        check("taken_lookup_0x104", 32'(bht_taken_o), 32'h1);

        // Fill the queue, drop the fifth push, then mispredict with a same-cycle push.
        for (int k = 0; k < 4; k++) pred(32'h110 + 32'(k * 4), 0, 32'h0);
        #1;
        check("full_not_ready", 32'(ready_o), 32'h0);
        pred(32'h120, 0, 32'h0);
        resolve(0, 32'h0);
        set_in(1, 32'h124, 0, 32'h0, 1, 1, 32'h250, 0);
        cycle();
        check("mp_push_redirect_addr", redirect_addr_o, 32'h250);
        resolve(0, 32'h0);
        check("empty_after_mp_err", 32'(err_o), 32'h1);
        check("empty_res_no_redirect", 32'(redirect_o), 32'h0);
        idle(3);
        check("err_sticky", 32'(err_o), 32'h1);

        // Taken with wrong target, and not-taken at the top of the address space.
        pred(32'h140, 1, 32'h300);
        resolve(1, 32'h304);
        check("target_redirect_addr", redirect_addr_o, 32'h304);
        pred(32'hFFFF_FFFC, 1, 32'h500);
        resolve(0, 32'h0);
        check("wrap_redirect_addr", redirect_addr_o, 32'h0);

        // Flush concurrent with a mispredicting resolution.
        pred(32'h108, 0, 32'h0);
        set_in(0, 32'h0, 0, 32'h0, 1, 1, 32'h600, 1);
        cycle();
        check("flush_no_redirect", 32'(redirect_o), 32'h0);
        check("flush_no_train", 32'(branch_taken_o), 32'h0);
        idle(2);

        // Reset during init at cycle 8 restarts the sweep.
        do_reset(1);
        idle(7);
        do_reset(1);
        check_init_len("reinit");

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] a;
            logic [31:0] rt;
            a  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'h100 + 32'($urandom_range(0, 31) * 4);
            rt = 32'h200 + 32'($urandom_range(0, 2) * 32'h100);
            if (m_q.size() > 0 && $urandom_range(0, 1) == 1) rt = m_q[0].target;
            rst = ($urandom_range(0, 299) == 0);
            set_in($urandom_range(0, 1) == 1, a, $urandom_range(0, 1) == 1,
                   32'h200 + 32'($urandom_range(0, 2) * 32'h100),
                   $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1, rt,
                   $urandom_range(0, 19) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
